// File: rtl/bytecode_fetch.sv
// bytecode_fetch: fetch stage ahead of the bytecode decoder.
// Streams bytes from a synchronous program memory (one-cycle read latency),
// assembles opcode + 0..2 immediate bytes, and hands each instruction to the
// decoder over a valid/ready handshake. Branch redirects restart fetch.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   run                 fetch enable, sampled in IDLE only
//   pmem_addr           byte address (combinationally equal to pc)
//   pmem_rdata          byte addressed on the previous cycle
//   instr_valid/ready   instruction handshake; fire = valid && ready
//   opcode, operand     instruction payload (operand big-endian for 2 bytes)
//   instr_len           operand byte count (0..2)
//   instr_pc            address of the opcode byte
//   redirect_en/pc      branch taken / target
//   illegal             sticky illegal-opcode flag
//
// Build option: define FETCH_ILLEGAL_TRAP_EN to trap on opcodes outside the
// legal set (illegal goes high, fetch parks in IDLE until redirect or rst).
// Without it, illegal is tied 0 and unknown opcodes are 0-operand.

module bytecode_fetch #(
   parameter int unsigned       ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   output logic [ADDR_W-1:0] pmem_addr,
   input  logic [7:0]        pmem_rdata,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [7:0]        opcode,
   output logic [15:0]       operand,
   output logic [1:0]        instr_len,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              redirect_en,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              illegal
);

   typedef enum logic [2:0] {IDLE, START, OP, ARG1, ARG2, OUT} state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic              redirect_ok;

   // Operand byte count per opcode; anything unlisted has no operands.
   function automatic logic [1:0] op_len(input logic [7:0] op);
      logic [1:0] len;
      len = 2'd0;
      case (op) inside
         8'h10, 8'h12, 8'h15, 8'h36, 8'hbc:                       len = 2'd1;
         8'h11, 8'h13, 8'h84, [8'h99:8'ha8], [8'hb2:8'hb8], 8'hbb: len = 2'd2;
         default:                                                 len = 2'd0;
      endcase
      return len;
   endfunction

`ifdef FETCH_ILLEGAL_TRAP_EN
   logic trap;

   // Legal set: every opcode with operands plus the known 0-operand ranges.
   function automatic logic op_legal(input logic [7:0] op);
      return (op_len(op) != 2'd0) ||
             (op inside {[8'h00:8'h0f], [8'h2e:8'h35], [8'h4f:8'h83],
                         [8'h85:8'h98], [8'hac:8'hb1]});
   endfunction

   assign illegal = trap;
`else
   assign illegal = 1'b0;
`endif

   assign pmem_addr = pc;

   // Redirect acts in any active state, and also wakes a trapped fetch.
   assign redirect_ok = redirect_en && ((state != IDLE) || illegal);

   // Fetch/assemble FSM; all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         instr_valid <= 1'b0;
         opcode      <= 8'h00;
         operand     <= 16'h0000;
         instr_len   <= 2'd0;
         instr_pc    <= '0;
`ifdef FETCH_ILLEGAL_TRAP_EN
         trap        <= 1'b0;
`endif
      end else if (redirect_ok) begin
         // Redirect wins over a same-cycle fire; any partial instruction is dropped.
         pc          <= redirect_pc;
         state       <= START;
         instr_valid <= 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
         trap        <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (run && !illegal) state <= START;
            end
            START: begin
               // Address goes out; first byte arrives in OP.
               pc    <= pc + ADDR_W'(1);
               state <= OP;
            end
            OP: begin
               opcode    <= pmem_rdata;
               instr_pc  <= pc - ADDR_W'(1);
               operand   <= 16'h0000;
               instr_len <= op_len(pmem_rdata);
`ifdef FETCH_ILLEGAL_TRAP_EN
               if (!op_legal(pmem_rdata)) begin
                  trap  <= 1'b1;
                  state <= IDLE;
               end else
`endif
               if (op_len(pmem_rdata) == 2'd0) begin
                  // pc already points at the next opcode.
                  state       <= OUT;
                  instr_valid <= 1'b1;
               end else begin
                  pc    <= pc + ADDR_W'(1);
                  state <= ARG1;
               end
            end
            ARG1: begin
               operand <= {8'h00, pmem_rdata};
               if (instr_len == 2'd2) begin
                  pc    <= pc + ADDR_W'(1);
                  state <= ARG2;
               end else begin
                  state       <= OUT;
                  instr_valid <= 1'b1;
               end
            end
            ARG2: begin
               operand     <= {operand[7:0], pmem_rdata};
               state       <= OUT;
               instr_valid <= 1'b1;
            end
            OUT: begin
               // pc holds the next opcode address, whose byte is already on rdata.
               if (instr_ready) begin
                  pc          <= pc + ADDR_W'(1);
                  state       <= OP;
                  instr_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bytecode_fetch.sv
// tb_bytecode_fetch: directed, table-driven bench for bytecode_fetch.
// Expected instructions live in a record table; hand sequences cover stall,
// redirect, redirect+fire, address wrap, async reset and illegal opcodes.

module tb_bytecode_fetch;

   logic        clk;
   logic        rst;
   logic        run;
   logic [7:0]  pmem_addr;
   logic [7:0]  pmem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [7:0]  opcode;
   logic [15:0] operand;
   logic [1:0]  instr_len;
   logic [7:0]  instr_pc;
   logic        redirect_en;
   logic [7:0]  redirect_pc;
   logic        illegal;

   bytecode_fetch #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .pmem_addr   (pmem_addr),
      .pmem_rdata  (pmem_rdata),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .opcode      (opcode),
      .operand     (operand),
      .instr_len   (instr_len),
      .instr_pc    (instr_pc),
      .redirect_en (redirect_en),
      .redirect_pc (redirect_pc),
      .illegal     (illegal)
   );

   // Synchronous program memory: data for the address of the previous cycle.
   logic [7:0] mem [256];
   always @(posedge clk) pmem_rdata <= mem[pmem_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          stall;    // cycles to hold ready low once valid is seen
      logic [7:0]  op;
      logic [15:0] operand;
      logic [1:0]  len;
      logic [7:0]  pc;
   } rec_t;

   rec_t tbl [11];
   int   n_cmp;
   int   n_fail;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
   endtask

   task automatic load_prog1();
      clear_mem();
      mem[0] = 8'h60; mem[1] = 8'h10; mem[2] = 8'h05;
      mem[3] = 8'h11; mem[4] = 8'h12; mem[5] = 8'h34;
      mem[8'h20] = 8'h10; mem[8'h21] = 8'h77;
   endtask

   task automatic do_reset();
      run         = 1'b0;
      instr_ready = 1'b0;
      redirect_en = 1'b0;
      redirect_pc = 8'h00;
      rst         = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Leaves the bench at the negedge where the DUT sits in START.
   task automatic start_run();
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
   endtask

   task automatic redir(input logic [7:0] target);
      redirect_pc = target;
      redirect_en = 1'b1;
      @(negedge clk);
      redirect_en = 1'b0;
   endtask

   task automatic wait_valid(input string nm);
      int n;
      n = 0;
      while (!instr_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!instr_valid) chk(nm, 32'(instr_valid), 32'd1);
   endtask

   // Called at the START negedge; latency from START to valid is 2 + len.
   task automatic collect(input int first, input int last);
      int gap;
      gap = 0;
      instr_ready = 1'b1;
      for (int i = first; i <= last; i++) begin
         while (!instr_valid && gap < 40) begin
            @(negedge clk);
            gap++;
         end
         if (!instr_valid) begin
            chk("valid_timeout", 32'(instr_valid), 32'd1);
            instr_ready = 1'b0;
            return;
         end
         chk("opcode",   32'(opcode),    32'(tbl[i].op));
         chk("operand",  32'(operand),   32'(tbl[i].operand));
         chk("len",      32'(instr_len), 32'(tbl[i].len));
         chk("instr_pc", 32'(instr_pc),  32'(tbl[i].pc));
         chk("latency",  32'(gap),       32'(2 + int'(tbl[i].len)));
         if (tbl[i].stall > 0) begin
            instr_ready = 1'b0;
            repeat (tbl[i].stall) begin
               @(negedge clk);
               chk("stall_valid",  32'(instr_valid), 32'd1);
               chk("stall_opcode", 32'(opcode),      32'(tbl[i].op));
               chk("stall_pc",     32'(instr_pc),    32'(tbl[i].pc));
               chk("stall_addr",   32'(pmem_addr),
                   32'(8'(tbl[i].pc + 8'd1 + 8'(tbl[i].len))));
            end
            instr_ready = 1'b1;
         end
         @(negedge clk);
         gap = 1;
      end
      instr_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      n_cmp  = 0;
      n_fail = 0;
      tbl[0]  = '{0, 8'h60, 16'h0000, 2'd0, 8'h00};
      tbl[1]  = '{0, 8'h10, 16'h0005, 2'd1, 8'h01};
      tbl[2]  = '{0, 8'h11, 16'h1234, 2'd2, 8'h03};
      tbl[3]  = '{0, 8'h00, 16'h0000, 2'd0, 8'h06};
      tbl[4]  = '{5, 8'h60, 16'h0000, 2'd0, 8'h00};
      tbl[5]  = '{0, 8'h10, 16'h0005, 2'd1, 8'h01};
      tbl[6]  = '{0, 8'h10, 16'h0077, 2'd1, 8'h20};
      tbl[7]  = '{0, 8'h11, 16'habcd, 2'd2, 8'hfe};
      tbl[8]  = '{0, 8'h60, 16'h0000, 2'd0, 8'h01};
      tbl[9]  = '{0, 8'hff, 16'h0000, 2'd0, 8'h00};
      tbl[10] = '{0, 8'h60, 16'h0000, 2'd0, 8'h04};

      // Reset state.
      load_prog1();
      do_reset();
      chk("rst_valid",   32'(instr_valid), 32'd0);
      chk("rst_addr",    32'(pmem_addr),   32'd0);
      chk("rst_opcode",  32'(opcode),      32'd0);
      chk("rst_operand", 32'(operand),     32'd0);
      chk("rst_len",     32'(instr_len),   32'd0);
      chk("rst_pc",      32'(instr_pc),    32'd0);
      chk("rst_illegal", 32'(illegal),     32'd0);

      // Streaming with ready held high.
      start_run();
      collect(0, 3);

      // Back-pressure on the first instruction.
      do_reset();
      start_run();
      collect(4, 5);

      // Redirect during ARG1 of a sipush discards it.
      clear_mem();
      mem[0] = 8'h11; mem[1] = 8'haa; mem[2] = 8'hbb;
      mem[8'h20] = 8'h10; mem[8'h21] = 8'h77;
      do_reset();
      start_run();
      @(negedge clk);            // OP
      @(negedge clk);            // ARG1
      redir(8'h20);
      collect(6, 6);

      // Redirect and fire together: redirect wins.
      load_prog1();
      do_reset();
      start_run();
      wait_valid("rf_timeout");
      instr_ready = 1'b1;
      redir(8'h20);
      chk("rf_valid", 32'(instr_valid), 32'd0);
      chk("rf_addr",  32'(pmem_addr),   32'h20);
      collect(6, 6);

      // Operand bytes straddle the address wrap.
      clear_mem();
      mem[8'hfe] = 8'h11; mem[8'hff] = 8'hab; mem[0] = 8'hcd; mem[1] = 8'h60;
      do_reset();
      start_run();
      redir(8'hfe);
      collect(7, 8);

      // Asynchronous reset while an instruction is held.
      load_prog1();
      do_reset();
      start_run();
      wait_valid("ar_timeout");
      #1 rst = 1'b1;
      #1;
      chk("ar_valid",  32'(instr_valid), 32'd0);
      chk("ar_addr",   32'(pmem_addr),   32'd0);
      chk("ar_opcode", 32'(opcode),      32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("ar_idle_valid", 32'(instr_valid), 32'd0);
      chk("ar_idle_addr",  32'(pmem_addr),   32'd0);
      start_run();
      collect(0, 0);

      // Opcode 0xFF at address 0.
      clear_mem();
      mem[0] = 8'hff; mem[4] = 8'h60;
      do_reset();
      start_run();
`ifdef FETCH_ILLEGAL_TRAP_EN
      seen = 1'b0;
      instr_ready = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (instr_valid) seen = 1'b1;
      end
      chk("ill_no_valid", 32'(seen),    32'd0);
      chk("ill_flag",     32'(illegal), 32'd1);
      start_run();
      repeat (3) begin
         @(negedge clk);
         if (instr_valid) seen = 1'b1;
      end
      chk("ill_run_ignored", 32'(seen),    32'd0);
      chk("ill_sticky",      32'(illegal), 32'd1);
      redir(8'h04);
      chk("ill_cleared", 32'(illegal), 32'd0);
      collect(10, 10);
`else
      seen = 1'b0;
      collect(9, 9);
      chk("ill_tied", 32'(illegal) | 32'(seen), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
